// File: rtl/mac_kbd_pkg.sv
// mac_kbd_pkg: shared constants, the Mac key word structure and the PS/2 set-2
// to Mac Plus keymap used by ps2_mac_kbd.
//   PS2_EXT / PS2_BRK / PS2_PAUSE : set-2 prefix bytes
//   MAC_NULL                      : idle key word shown after reset
//   mac_key_t                     : {pfx71, pfx79, valid, code[5:0]}
//   ps2_to_mac(ext, sc)           : keymap lookup, valid=0 on a miss
//   ps2_ignored(sc)               : protocol/ack bytes that carry no key
package mac_kbd_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;
    localparam logic [9:0] MAC_NULL  = 10'h07B;

    typedef struct packed {
        logic       pfx71;
        logic       pfx79;
        logic       valid;
        logic [5:0] code;
    } mac_key_t;

    function automatic mac_key_t mk_key(input logic p71, input logic p79, input logic [5:0] c);
        mac_key_t k;
        k.pfx71 = p71;
        k.pfx79 = p79;
        k.valid = 1'b1;
        k.code  = c;
        return k;
    endfunction

    function automatic logic ps2_ignored(input logic [7:0] sc);
        return sc inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
    endfunction

    // Keypad keys carry the 0x79 prefix; the shifted keypad operators
    // (*, +, /) need both 0x71 and 0x79. E0 12 / E0 59 (fake shifts) are
    // deliberately absent so they fall through as misses.
    function automatic mac_key_t ps2_to_mac(input logic ext, input logic [7:0] sc);
        mac_key_t k;
        k = '0;
        case ({ext, sc})
            9'h01C: k = mk_key(0, 0, 6'h00);  9'h01B: k = mk_key(0, 0, 6'h01);
            9'h023: k = mk_key(0, 0, 6'h02);  9'h02B: k = mk_key(0, 0, 6'h03);
            9'h033: k = mk_key(0, 0, 6'h04);  9'h034: k = mk_key(0, 0, 6'h05);
            9'h01A: k = mk_key(0, 0, 6'h06);  9'h022: k = mk_key(0, 0, 6'h07);
            9'h021: k = mk_key(0, 0, 6'h08);  9'h02A: k = mk_key(0, 0, 6'h09);
            9'h032: k = mk_key(0, 0, 6'h0B);  9'h015: k = mk_key(0, 0, 6'h0C);
            9'h01D: k = mk_key(0, 0, 6'h0D);  9'h024: k = mk_key(0, 0, 6'h0E);
            9'h02D: k = mk_key(0, 0, 6'h0F);  9'h035: k = mk_key(0, 0, 6'h10);
            9'h02C: k = mk_key(0, 0, 6'h11);  9'h016: k = mk_key(0, 0, 6'h12);
            9'h01E: k = mk_key(0, 0, 6'h13);  9'h026: k = mk_key(0, 0, 6'h14);
            9'h025: k = mk_key(0, 0, 6'h15);  9'h036: k = mk_key(0, 0, 6'h16);
            9'h02E: k = mk_key(0, 0, 6'h17);  9'h055: k = mk_key(0, 0, 6'h18);
            9'h046: k = mk_key(0, 0, 6'h19);  9'h03D: k = mk_key(0, 0, 6'h1A);
            9'h04E: k = mk_key(0, 0, 6'h1B);  9'h03E: k = mk_key(0, 0, 6'h1C);
            9'h045: k = mk_key(0, 0, 6'h1D);  9'h05B: k = mk_key(0, 0, 6'h1E);
            9'h044: k = mk_key(0, 0, 6'h1F);  9'h03C: k = mk_key(0, 0, 6'h20);
            9'h054: k = mk_key(0, 0, 6'h21);  9'h043: k = mk_key(0, 0, 6'h22);
            9'h04D: k = mk_key(0, 0, 6'h23);  9'h05A: k = mk_key(0, 0, 6'h24);
            9'h04B: k = mk_key(0, 0, 6'h25);  9'h03B: k = mk_key(0, 0, 6'h26);
            9'h052: k = mk_key(0, 0, 6'h27);  9'h042: k = mk_key(0, 0, 6'h28);
            9'h04C: k = mk_key(0, 0, 6'h29);  9'h05D: k = mk_key(0, 0, 6'h2A);
            9'h041: k = mk_key(0, 0, 6'h2B);  9'h04A: k = mk_key(0, 0, 6'h2C);
            9'h031: k = mk_key(0, 0, 6'h2D);  9'h03A: k = mk_key(0, 0, 6'h2E);
            9'h049: k = mk_key(0, 0, 6'h2F);  9'h00D: k = mk_key(0, 0, 6'h30);
            9'h029: k = mk_key(0, 0, 6'h31);  9'h00E: k = mk_key(0, 0, 6'h32);
            9'h066: k = mk_key(0, 0, 6'h33);  9'h014: k = mk_key(0, 0, 6'h37);
            9'h012: k = mk_key(0, 0, 6'h38);  9'h059: k = mk_key(0, 0, 6'h38);
            9'h058: k = mk_key(0, 0, 6'h39);  9'h011: k = mk_key(0, 0, 6'h3A);
            9'h114: k = mk_key(0, 0, 6'h37);  9'h11F: k = mk_key(0, 0, 6'h37);
            9'h111: k = mk_key(0, 0, 6'h3A);
            // keypad
            9'h070: k = mk_key(0, 1, 6'h26);  9'h069: k = mk_key(0, 1, 6'h27);
            9'h072: k = mk_key(0, 1, 6'h28);  9'h07A: k = mk_key(0, 1, 6'h29);
            9'h06B: k = mk_key(0, 1, 6'h2A);  9'h073: k = mk_key(0, 1, 6'h2B);
            9'h074: k = mk_key(0, 1, 6'h2C);  9'h06C: k = mk_key(0, 1, 6'h2D);
            9'h075: k = mk_key(0, 1, 6'h2F);  9'h07D: k = mk_key(0, 1, 6'h30);
            9'h071: k = mk_key(0, 1, 6'h15);  9'h07B: k = mk_key(0, 1, 6'h22);
            9'h077: k = mk_key(0, 1, 6'h1B);  9'h15A: k = mk_key(0, 1, 6'h20);
            9'h07C: k = mk_key(1, 1, 6'h02);  9'h079: k = mk_key(1, 1, 6'h06);
            9'h14A: k = mk_key(1, 1, 6'h0D);
            // arrows
            9'h175: k = mk_key(0, 1, 6'h0D);  9'h172: k = mk_key(0, 1, 6'h08);
            9'h16B: k = mk_key(0, 1, 6'h06);  9'h174: k = mk_key(0, 1, 6'h02);
            default: k = '0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver.
//   clk, reset, en       : system clock, async active-high reset, clock enable
//   ps2_clk, ps2_data    : raw asynchronous PS/2 pins
//   rx_byte              : last received byte, valid while byte_valid=1
//   byte_valid           : one en-cycle pulse after a good stop bit
//   frame_err            : one en-cycle pulse on bad parity or stop bit
module ps2_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [FW-1:0] FL_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);

    logic [1:0]    clk_sy, dat_sy;
    logic          filt;
    logic [FW-1:0] fcnt;
    logic          fall, dat;
    logic [3:0]    bitcnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] tcnt;

    assign dat = dat_sy[1];
    // Filtered clock is about to drop on this en-cycle: the FILTER_LEN-th
    // consecutive low sample while the filtered level is still high.
    assign fall = filt & ~clk_sy[1] & (fcnt == FL_MAX);
    // shreg is untouched until the next frame's data bits, so it is stable
    // during the byte_valid pulse.
    assign rx_byte = shreg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sy <= 2'b11;
            dat_sy <= 2'b11;
            filt   <= 1'b1;
            fcnt   <= '0;
        end else if (en) begin
            clk_sy <= {clk_sy[0], ps2_clk};
            dat_sy <= {dat_sy[0], ps2_data};
            if (clk_sy[1] == filt) begin
                fcnt <= '0;
            end else if (fcnt == FL_MAX) begin
                filt <= clk_sy[1];
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bitcnt     <= 4'd0;
            shreg      <= 8'h00;
            par        <= 1'b0;
            tcnt       <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else if (en) begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                tcnt <= '0;
                if (bitcnt == 4'd0) begin
                    if (!dat) bitcnt <= 4'd1;   // a high start bit is noise
                end else if (bitcnt <= 4'd8) begin
                    shreg  <= {dat, shreg[7:1]};
                    bitcnt <= bitcnt + 4'd1;
                end else if (bitcnt == 4'd9) begin
                    par    <= dat;
                    bitcnt <= 4'd10;
                end else begin
                    bitcnt <= 4'd0;
                    if (dat && (^{shreg, par})) byte_valid <= 1'b1;
                    else                        frame_err  <= 1'b1;
                end
            end else if (bitcnt != 4'd0) begin
                if (tcnt == TO_MAX) begin
                    bitcnt <= 4'd0;
                    tcnt   <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end else begin
                tcnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_mac_kbd.sv
// ps2_mac_kbd: PS/2 set-2 keyboard to Mac Plus key word translator.
//   clk, reset, en      : system clock, async active-high reset, clock enable
//   ps2_clk, ps2_data   : raw PS/2 pins
//   kbd_strobe          : toggles once per new key word
//   kbd_data            : {pfx71, pfx79, release, code[5:0], 1'b1}
//   frame_err           : one en-cycle pulse on a bad PS/2 frame
module ps2_mac_kbd
    import mac_kbd_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       kbd_strobe,
    output logic [9:0] kbd_data,
    output logic       frame_err
);
    logic [7:0] rx_byte;
    logic       rx_valid;

    ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (rx_valid),
        .frame_err  (frame_err)
    );

    logic       ext, brk, ext_n, brk_n;
    logic [2:0] skip, skip_n;
    logic [8:0] last_make, last_n, key_id;
    logic [9:0] data_n;
    logic       strobe_n;
    mac_key_t   lut;

    assign key_id = {ext, rx_byte};
    assign lut    = ps2_to_mac(ext, rx_byte);

    always_comb begin
        ext_n    = ext;
        brk_n    = brk;
        skip_n   = skip;
        last_n   = last_make;
        data_n   = kbd_data;
        strobe_n = kbd_strobe;
        if (rx_valid) begin
            if (skip != 3'd0) begin
                skip_n = skip - 3'd1;           // swallowing the Pause sequence
            end else if (rx_byte == PS2_PAUSE) begin
                skip_n = 3'd7;
            end else if (rx_byte == PS2_EXT) begin
                ext_n = 1'b1;
            end else if (rx_byte == PS2_BRK) begin
                brk_n = 1'b1;
            end else if (!ext && !brk && ps2_ignored(rx_byte)) begin
                ext_n = ext;                    // ack/status byte, no effect
            end else begin
                ext_n = 1'b0;
                brk_n = 1'b0;
                if (lut.valid && (brk || key_id != last_make)) begin
                    data_n   = {lut.pfx71, lut.pfx79, brk, lut.code, 1'b1};
                    strobe_n = ~kbd_strobe;
                end
                // Only a break of the held key re-arms it; a fresh make arms it.
                if (lut.valid && brk && key_id == last_make) last_n = '0;
                if (lut.valid && !brk)                       last_n = key_id;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext        <= 1'b0;
            brk        <= 1'b0;
            skip       <= 3'd0;
            last_make  <= '0;
            kbd_data   <= MAC_NULL;
            kbd_strobe <= 1'b0;
        end else if (en) begin
            ext        <= ext_n;
            brk        <= brk_n;
            skip       <= skip_n;
            last_make  <= last_n;
            kbd_data   <= data_n;
            kbd_strobe <= strobe_n;
        end
    end

endmodule

// File: tb/tb_ps2_mac_kbd.sv
// tb_ps2_mac_kbd: drives PS/2 frames into ps2_mac_kbd and compares the key
// words seen on strobe toggles against a byte-level reference model.
module tb_ps2_mac_kbd;
    localparam int HALF = 12;   // clk cycles per PS/2 clock half period
    localparam int FLEN = 4;
    localparam int TOUT = 128;

    logic       clk, reset, en, ps2_clk, ps2_data;
    logic       kbd_strobe, frame_err;
    logic [9:0] kbd_data;

    ps2_mac_kbd #(.FILTER_LEN(FLEN), .TIMEOUT(TOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .kbd_strobe (kbd_strobe),
        .kbd_data   (kbd_data),
        .frame_err  (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         n_chk = 0, n_fail = 0;
    int         fe_cnt = 0, exp_fe = 0;
    logic [9:0] got_q[$], exp_q[$];
    logic [9:0] kmap[int];       // {ext,scancode} -> make word
    int         keys[$];
    bit         m_ext, m_brk;
    int         m_skip, m_last;
    bit         en_rand = 1'b0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Event monitor: every strobe edge delivers one word; count frame_err pulses.
    logic prev_stb = 1'b0, prev_fe = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_stb = 1'b0;
            prev_fe  = 1'b0;
        end else begin
            if (kbd_strobe !== prev_stb) got_q.push_back(kbd_data);
            if (frame_err && !prev_fe) fe_cnt++;
            prev_stb = kbd_strobe;
            prev_fe  = frame_err;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            en = en_rand ? ($urandom_range(0, 7) != 0) : 1'b1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_skip = 0; m_last = -1;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int  id;
        bit  was_brk;
        if (m_skip > 0) begin m_skip--; return; end
        if (b == 8'hE1) begin m_skip = 7; return; end
        if (b == 8'hE0) begin m_ext = 1; return; end
        if (b == 8'hF0) begin m_brk = 1; return; end
        if (!m_ext && !m_brk && (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF})) return;
        id      = (m_ext ? 256 : 0) + int'(b);
        was_brk = m_brk;
        m_ext   = 0;
        m_brk   = 0;
        if (!kmap.exists(id)) return;
        if (was_brk) begin
            exp_q.push_back(kmap[id] | 10'h080);
            if (id == m_last) m_last = -1;
        end else if (id != m_last) begin
            exp_q.push_back(kmap[id]);
            m_last = id;
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        logic p;
        p = ~(^b) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(p);
        ps2_bit(1'b1);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0);
        model_byte(b);
    endtask

    task automatic press(input int id);
        if (id >= 256) send_byte(8'hE0);
        send_byte(id[7:0]);
    endtask

    task automatic release_key(input int id);
        if (id >= 256) send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(id[7:0]);
    endtask

    task automatic send_pause();
        logic [7:0] seq [8];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 8; i++) send_byte(seq[i]);
    endtask

    task automatic check_events(input string tag);
        repeat (20) @(negedge clk);
        chk({tag, ":count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk({tag, ":word"}, int'(got_q[i]), int'(exp_q[i]));
            chk({tag, ":bit0"}, int'(got_q[i][0]), 1);
        end
        chk({tag, ":ferr"}, fe_cnt, exp_fe);
        got_q.delete();
        exp_q.delete();
    endtask

    int r, k, last_k;

    initial begin
        kmap['h01C] = 10'h001; kmap['h01B] = 10'h003; kmap['h023] = 10'h005;
        kmap['h015] = 10'h019; kmap['h05A] = 10'h049; kmap['h029] = 10'h063;
        kmap['h012] = 10'h071; kmap['h069] = 10'h14F; kmap['h07C] = 10'h305;
        kmap['h175] = 10'h11B; kmap['h172] = 10'h111; kmap['h114] = 10'h06F;
        foreach (kmap[i]) keys.push_back(i);
        model_reset();

        reset = 1'b1; en = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst:strobe", int'(kbd_strobe), 0);
        chk("rst:data", int'(kbd_data), 'h07B);
        chk("rst:ferr", int'(frame_err), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        en_rand = 1'b1;

        // 'A' make then break
        press('h01C); release_key('h01C);
        check_events("keyA");
        // space with typematic repeats
        press('h029); press('h029); press('h029); release_key('h029);
        check_events("space");
        // keypad 1, up arrow, keypad *
        press('h069); press('h175); press('h07C);
        check_events("keypad");
        // bad parity then a good 'A'
        send_frame(8'h1C, 1'b1); exp_fe++;
        press('h01C);
        check_events("parity");
        // partial frame, stall past timeout, then a full frame
        release_key('h01C);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (2 * (TOUT + 10)) @(negedge clk);
        press('h01C);
        check_events("timeout");
        // Pause produces nothing; next key still works
        release_key('h01C);
        send_pause();
        press('h01C);
        check_events("pause");

        // randomized key traffic
        last_k = keys[0];
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 15);
            k = keys[$urandom_range(0, keys.size() - 1)];
            if (r <= 3)       begin press(k); last_k = k; end
            else if (r <= 5)  press(last_k);
            else if (r <= 8)  release_key($urandom_range(0, 1) != 0 ? last_k : k);
            else if (r == 9)  send_byte(8'hAA ^ (($urandom_range(0, 1) != 0) ? 8'h50 : 8'h00));
            else if (r == 10) press($urandom_range(0, 1) != 0 ? 'h112 : 'h07E);
            else if (r == 11) begin send_frame(8'($urandom_range(0, 255)), 1'b1); exp_fe++; end
            else if (r == 12) send_pause();
            else              begin press(k); release_key(k); end
        end
        check_events("rand");

        // reset in the middle of a frame
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst:strobe", int'(kbd_strobe), 0);
        chk("midrst:data", int'(kbd_data), 'h07B);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        model_reset();
        got_q.delete();
        repeat (5) @(negedge clk);
        press('h01C);
        check_events("postrst");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_mac_kbd.md
Name: ps2_mac_kbd

Overview:
Upstream feeder for the Mac Plus keyboard responder. Receives a PS/2 set-2 keyboard stream on raw ps2_clk/ps2_data pins, deframes bytes, and tracks E0/F0/E1 prefixes. Translates each make/break into a 10-bit Mac Plus key word and presents it on kbd_data, signalled by a toggle on kbd_strobe; the consumer latches on any strobe edge.

Parameters:
FILTER_LEN, 8, consecutive identical en-samples needed to accept a ps2_clk level change (2..16)
TIMEOUT, 4096, en-cycles without a ps2_clk falling edge before a partial frame is aborted

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
en  in  1  clock enable; all state advances only when en=1
ps2_clk  in  1  raw PS/2 clock pin, asynchronous
ps2_data  in  1  raw PS/2 data pin, asynchronous
kbd_strobe  out  1  toggles once per new key word
kbd_data  out  10  [9]=shift-keypad prefix 0x71, [8]=keypad prefix 0x79, [7]=release, [6:1]=Mac keycode, [0]=1
frame_err  out  1  one-en-cycle pulse on a parity or stop-bit error

Behaviour:
- Reset values: kbd_strobe=0, kbd_data=10'h07B (null word), frame_err=0. Receiver idle, prefix flags clear, last_make=0.
- Sync: ps2_clk and ps2_data each pass through 2 flops. The filtered clock changes only after FILTER_LEN equal samples. A falling edge of the filtered clock samples synced data.
- Frame: start(0), 8 data bits LSB first, odd parity, stop(1). A bit counter runs 0..10.
- Start bit sampled as 1: ignore it; the counter stays 0.
- Parity bad or stop=0: discard the byte, pulse frame_err, return to idle.
- Timeout: counter nonzero and TIMEOUT en-cycles without a falling edge: abort to idle. No frame_err. The timeout counter clears on every falling edge.
- Good frame: byte_valid pulses for 1 en-cycle, on the cycle after the stop bit is sampled.
- Decoder state registers: ext (E0 seen), brk (F0 seen), skip (0..7).
- E1 sets skip=7. While skip>0, each byte decrements skip and is otherwise ignored. Pause produces no output.
- E0 sets ext. F0 sets brk.
- 0x00, 0xAA, 0xEE, 0xFA, 0xFC, 0xFE, 0xFF with no prefix are ignored.
- Any other byte: look up the Mac word from {ext, byte}, then clear ext and brk.
- Lookup miss (including E0 12 / E0 59 fake shifts): no output.
- Typematic suppression: a make whose {ext,byte} equals last_make is dropped. A make updates last_make. The break of last_make clears it; other breaks leave it.
- Output: on a valid translated event, kbd_data = {pfx71, pfx79, brk, code[5:0], 1'b1}. kbd_strobe inverts in the same clk edge.
- Latency: kbd_data/kbd_strobe update exactly 1 en-cycle after byte_valid.
- kbd_data holds until the next event. Strobe toggles are ≥1 PS/2 frame apart (≈1 ms), well above the consumer's single-cycle edge detect.
- Simultaneous events: E0/F0 arrival and a timeout cannot coincide, because byte_valid implies a recent edge. reset mid-frame returns everything to reset values within the same clk.
- en=0 freezes all state, including the synchronizer flops and filter.

Decomposition:
- Package mac_kbd_pkg:
  - prefix constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1
  - MAC_NULL=10'h07B
  - mac_key_t packed struct {pfx71, pfx79, valid, code[5:0]}
  - pure function ps2_to_mac(ext, byte) implementing the keymap case table
- Sub-module ps2_rx: synchronizer, filter, framing, timeout; outputs byte[7:0], byte_valid, frame_err.
- The top level holds the prefix FSM, repeat suppression and the output register.

Test Plan:
- Send 1C then F0 1C ('A') -> kbd_data=0x001 with strobe 0->1, then kbd_data=0x081 with strobe 1->0. Exactly two toggles.
- Send 29 29 29 F0 29 (space, typematic) -> outputs only 0x063 then 0x0E3.
- Send keypad '1' (69) -> 0x14F. Send E0 75 (up arrow) -> 0x11B. Send keypad '*' (7C) -> 0x305. Each output has bit0=1.
- Frame 1C with bad parity -> frame_err pulses once, no strobe toggle. Next valid 1C -> 0x001.
- Send 5 bits of a frame, stall ps2_clk for TIMEOUT+10 cycles, then a full 1C frame -> 0x001, no frame_err.
- Send the Pause sequence E1 14 77 E1 F0 14 F0 77, then 1C -> no toggle during Pause; 0x001 after it. Assert reset mid-frame -> kbd_data=0x07B, kbd_strobe=0.
